// File: rtl/cue_shot_controller_if.sv
// Velocity write bus from the shot controller to the ball motion logic.
// The controller drives the master side; the ball logic listens on the slave side.
interface cue_shot_controller_if;
  logic               velocityWriteEnable;
  logic signed [10:0] outVelocityX;
  logic signed [10:0] outVelocityY;

  modport master (
    output velocityWriteEnable,
    output outVelocityX,
    output outVelocityY
  );

  modport slave (
    input velocityWriteEnable,
    input outVelocityX,
    input outVelocityY
  );
endinterface

// File: rtl/cue_shot_controller.sv
// Cue aim/charge/fire stage: rotates the aim, charges power while held, fires a one-cycle
// velocity write on release, then waits for the ball to settle before re-enabling aim.
module cue_shot_controller #(
  parameter int unsigned MAX_POWER     = 200,
  parameter int unsigned MIN_POWER     = 8,
  parameter int unsigned POWER_STEP    = 4,
  parameter int unsigned ROTATE_FRAMES = 6,
  parameter int unsigned SETTLE_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          startOfFrame,
  input  logic                          ballStopped,
  input  logic                          keyRotateCW,
  input  logic                          keyRotateCCW,
  input  logic                          keyCharge,
  cue_shot_controller_if.master         vel,
  output logic [3:0]                    aimAngle,
  output logic [7:0]                    power,
  output logic                          aimEnable,
  output logic [7:0]                    shotCount
);

  localparam logic [7:0] PowerMax   = 8'(MAX_POWER);
  localparam logic [7:0] PowerMin   = 8'(MIN_POWER);
  localparam logic [7:0] PowerStep  = 8'(POWER_STEP);
  localparam logic [7:0] PowerSat   = 8'(MAX_POWER - POWER_STEP);
  localparam logic [7:0] RotateLast = 8'(ROTATE_FRAMES - 1);
  localparam logic [7:0] SettleLast = 8'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {StSettle, StAim, StCharge, StFire} state_e;

  state_e      state_q;
  logic [7:0]  settle_cnt_q;
  logic [7:0]  rotate_cnt_q;

  logic signed [7:0]  dir_x, dir_y;
  logic signed [15:0] prod_x, prod_y, power_s;
  logic signed [10:0] vel_x, vel_y;

  // Direction table: k*22.5 deg, X = round(64 cos), Y = -round(64 sin) (screen Y down).
  always_comb begin
    dir_x = 8'sd0;
    dir_y = 8'sd0;
    unique case (aimAngle)
      4'd0:  begin dir_x =  8'sd64; dir_y =  8'sd0;  end
      4'd1:  begin dir_x =  8'sd59; dir_y = -8'sd24; end
      4'd2:  begin dir_x =  8'sd45; dir_y = -8'sd45; end
      4'd3:  begin dir_x =  8'sd24; dir_y = -8'sd59; end
      4'd4:  begin dir_x =  8'sd0;  dir_y = -8'sd64; end
      4'd5:  begin dir_x = -8'sd24; dir_y = -8'sd59; end
      4'd6:  begin dir_x = -8'sd45; dir_y = -8'sd45; end
      4'd7:  begin dir_x = -8'sd59; dir_y = -8'sd24; end
      4'd8:  begin dir_x = -8'sd64; dir_y =  8'sd0;  end
      4'd9:  begin dir_x = -8'sd59; dir_y =  8'sd24; end
      4'd10: begin dir_x = -8'sd45; dir_y =  8'sd45; end
      4'd11: begin dir_x = -8'sd24; dir_y =  8'sd59; end
      4'd12: begin dir_x =  8'sd0;  dir_y =  8'sd64; end
      4'd13: begin dir_x =  8'sd24; dir_y =  8'sd59; end
      4'd14: begin dir_x =  8'sd45; dir_y =  8'sd45; end
      4'd15: begin dir_x =  8'sd59; dir_y =  8'sd24; end
      default: ;
    endcase
  end

  // Power is unsigned; zero-extend before the signed multiply, then floor-divide by 64.
  always_comb begin
    power_s = $signed({8'd0, power});
    prod_x  = 16'(dir_x) * power_s;
    prod_y  = 16'(dir_y) * power_s;
    vel_x   = 11'(prod_x >>> 6);
    vel_y   = 11'(prod_y >>> 6);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                 <= StSettle;
      settle_cnt_q            <= '0;
      rotate_cnt_q            <= '0;
      aimAngle                <= '0;
      power                   <= '0;
      aimEnable               <= 1'b0;
      shotCount               <= '0;
      vel.velocityWriteEnable <= 1'b0;
      vel.outVelocityX        <= '0;
      vel.outVelocityY        <= '0;
    end else begin
      unique case (state_q)
        StSettle: begin
          if (startOfFrame) begin
            if (!ballStopped) begin
              settle_cnt_q <= '0;
            end else if (settle_cnt_q == SettleLast) begin
              settle_cnt_q <= '0;
              state_q      <= StAim;
              aimEnable    <= 1'b1;
            end else begin
              settle_cnt_q <= settle_cnt_q + 8'd1;
            end
          end
        end
        StAim: begin
          // Charge wins over a rotation step landing in the same cycle.
          if (keyCharge) begin
            state_q      <= StCharge;
            power        <= '0;
            rotate_cnt_q <= '0;
          end else if (startOfFrame) begin
            if (keyRotateCW ^ keyRotateCCW) begin
              if (rotate_cnt_q == RotateLast) begin
                rotate_cnt_q <= '0;
                aimAngle     <= keyRotateCW ? aimAngle - 4'd1 : aimAngle + 4'd1;
              end else begin
                rotate_cnt_q <= rotate_cnt_q + 8'd1;
              end
            end else begin
              rotate_cnt_q <= '0;
            end
          end
        end
        StCharge: begin
          if (!keyCharge) begin
            if (power >= PowerMin) begin
              state_q                 <= StFire;
              aimEnable               <= 1'b0;
              vel.velocityWriteEnable <= 1'b1;
              vel.outVelocityX        <= vel_x;
              vel.outVelocityY        <= vel_y;
            end else begin
              state_q <= StAim;
              power   <= '0;
            end
          end else if (startOfFrame) begin
            power <= (power >= PowerSat) ? PowerMax : power + PowerStep;
          end
        end
        StFire: begin
          vel.velocityWriteEnable <= 1'b0;
          shotCount               <= shotCount + 8'd1;
          power                   <= '0;
          settle_cnt_q            <= '0;
          state_q                 <= StSettle;
        end
        default: state_q <= StSettle;
      endcase
    end
  end

endmodule

// File: tb/tb_cue_shot_controller.sv
// Self-checking bench for cue_shot_controller: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the shot rules.
module tb_cue_shot_controller;

  localparam real PI = 3.14159265358979;

  logic       clk = 1'b0;
  logic       reset, startOfFrame, ballStopped, keyRotateCW, keyRotateCCW, keyCharge;
  logic [3:0] aimAngle;
  logic [7:0] power, shotCount;
  logic       aimEnable;

  cue_shot_controller_if vel_if ();

  cue_shot_controller dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .ballStopped  (ballStopped),
    .keyRotateCW  (keyRotateCW),
    .keyRotateCCW (keyRotateCCW),
    .keyCharge    (keyCharge),
    .vel          (vel_if.master),
    .aimAngle     (aimAngle),
    .power        (power),
    .aimEnable    (aimEnable),
    .shotCount    (shotCount)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural reference state
  string m_mode;
  int    m_settle, m_rot, m_ang, m_pw, m_vx, m_vy, m_wen, m_shots;

  function automatic int dir_x(int k);
    return int'(64.0 * $cos(real'(k) * PI / 8.0));
  endfunction

  function automatic int dir_y(int k);
    return -int'(64.0 * $sin(real'(k) * PI / 8.0));
  endfunction

  function automatic int shot_vel(int d, int p);
    return int'($floor(real'(d * p) / 64.0));
  endfunction

  function automatic int m_aim();
    return (m_mode == "aim" || m_mode == "charge") ? 1 : 0;
  endfunction

  task automatic model_step(input bit sof, stp, cw, ccw, chg, rst);
    if (rst) begin
      m_mode = "settle"; m_settle = 0; m_rot = 0; m_ang = 0; m_pw = 0;
      m_vx = 0; m_vy = 0; m_wen = 0; m_shots = 0;
    end else if (m_mode == "settle") begin
      if (sof) begin
        m_settle = stp ? m_settle + 1 : 0;
        if (m_settle == 30) begin m_mode = "aim"; m_settle = 0; end
      end
    end else if (m_mode == "aim") begin
      if (chg) begin
        m_mode = "charge"; m_pw = 0; m_rot = 0;
      end else if (sof) begin
        if (cw != ccw) begin
          m_rot++;
          if (m_rot == 6) begin m_rot = 0; m_ang = cw ? (m_ang + 15) % 16 : (m_ang + 1) % 16; end
        end else m_rot = 0;
      end
    end else if (m_mode == "charge") begin
      if (!chg) begin
        if (m_pw >= 8) begin
          m_mode = "fire"; m_wen = 1;
          m_vx = shot_vel(dir_x(m_ang), m_pw);
          m_vy = shot_vel(dir_y(m_ang), m_pw);
        end else begin
          m_mode = "aim"; m_pw = 0;
        end
      end else if (sof) begin
        m_pw = (m_pw + 4 > 200) ? 200 : m_pw + 4;
      end
    end else begin
      m_wen = 0; m_shots = (m_shots + 1) % 256; m_pw = 0; m_settle = 0; m_mode = "settle";
    end
  endtask

  task automatic tick(input bit sof, stp, cw, ccw, chg, rst);
    startOfFrame = sof; ballStopped = stp; keyRotateCW = cw;
    keyRotateCCW = ccw; keyCharge = chg; reset = rst;
    @(posedge clk);
    model_step(sof, stp, cw, ccw, chg, rst);
    #1;
  endtask

  // n frame pulses, each followed by an idle cycle, with keys held as given
  task automatic frames(input int n, input bit stp, cw, ccw, chg);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, stp, cw, ccw, chg, 1'b0);
      tick(1'b0, stp, cw, ccw, chg, 1'b0);
    end
  endtask

  task automatic settle_to_aim();
    frames(30, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (aimEnable !== 1'b0) begin n_fail++; $display("FAIL reset_aim got %0d want 0", aimEnable); end
    n_cmp++; if (power !== 8'd0) begin n_fail++; $display("FAIL reset_power got %0d want 0", power); end
    n_cmp++; if (aimAngle !== 4'd0) begin n_fail++; $display("FAIL reset_angle got %0d want 0", aimAngle); end
    n_cmp++; if (shotCount !== 8'd0) begin n_fail++; $display("FAIL reset_shots got %0d want 0", shotCount); end
    n_cmp++; if (vel_if.velocityWriteEnable !== 1'b0) begin
      n_fail++; $display("FAIL reset_wen got %0d want 0", vel_if.velocityWriteEnable);
    end
    n_cmp++; if (vel_if.outVelocityX !== 11'd0 || vel_if.outVelocityY !== 11'd0) begin
      n_fail++; $display("FAIL reset_vel got %0d,%0d want 0,0", vel_if.outVelocityX, vel_if.outVelocityY);
    end
  endtask

  task automatic test_settle();
    frames(29, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (aimEnable !== 1'b0) begin n_fail++; $display("FAIL settle_29 got %0d want 0", aimEnable); end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (aimEnable !== 1'b1) begin n_fail++; $display("FAIL settle_30 got %0d want 1", aimEnable); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_rotate();
    frames(12, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (aimAngle !== 4'd2) begin n_fail++; $display("FAIL rot_ccw12 got %0d want 2", aimAngle); end
    frames(12, 1'b1, 1'b1, 1'b0, 1'b0);
    frames(6, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (aimAngle !== 4'd15) begin n_fail++; $display("FAIL rot_cw_wrap got %0d want 15", aimAngle); end
    frames(6, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (aimAngle !== 4'd15) begin n_fail++; $display("FAIL rot_both got %0d want 15", aimAngle); end
    frames(6, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (aimAngle !== 4'd0) begin n_fail++; $display("FAIL rot_ccw_wrap got %0d want 0", aimAngle); end
  endtask

  task automatic test_charge_saturate();
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frames(60, 1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (power !== 8'd200) begin n_fail++; $display("FAIL sat_power got %0d want 200", power); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (vel_if.velocityWriteEnable !== 1'b1 || $signed(vel_if.outVelocityX) !== 11'sd200
                 || $signed(vel_if.outVelocityY) !== 11'sd0) begin
      n_fail++; $display("FAIL sat_fire got wen=%0d x=%0d y=%0d want 1,200,0",
                         vel_if.velocityWriteEnable, $signed(vel_if.outVelocityX),
                         $signed(vel_if.outVelocityY));
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (vel_if.velocityWriteEnable !== 1'b0 || shotCount !== 8'd1) begin
      n_fail++; $display("FAIL sat_after got wen=%0d shots=%0d want 0,1",
                         vel_if.velocityWriteEnable, shotCount);
    end
    settle_to_aim();
  endtask

  task automatic test_angle2_shot();
    frames(12, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frames(10, 1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (power !== 8'd40) begin n_fail++; $display("FAIL a2_power got %0d want 40", power); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (vel_if.velocityWriteEnable !== 1'b1 || $signed(vel_if.outVelocityX) !== 11'sd28
                 || $signed(vel_if.outVelocityY) !== -11'sd29) begin
      n_fail++; $display("FAIL a2_fire got wen=%0d x=%0d y=%0d want 1,28,-29",
                         vel_if.velocityWriteEnable, $signed(vel_if.outVelocityX),
                         $signed(vel_if.outVelocityY));
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (vel_if.velocityWriteEnable !== 1'b0 || $signed(vel_if.outVelocityX) !== 11'sd28) begin
      n_fail++; $display("FAIL a2_pulse got wen=%0d x=%0d want 0,28",
                         vel_if.velocityWriteEnable, $signed(vel_if.outVelocityX));
    end
    settle_to_aim();
  endtask

  task automatic test_cancel();
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frames(1, 1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (power !== 8'd4) begin n_fail++; $display("FAIL cancel_power got %0d want 4", power); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (vel_if.velocityWriteEnable !== 1'b0 || aimEnable !== 1'b1 || power !== 8'd0
                 || shotCount !== 8'd2) begin
      n_fail++; $display("FAIL cancel got wen=%0d aim=%0d pw=%0d shots=%0d want 0,1,0,2",
                         vel_if.velocityWriteEnable, aimEnable, power, shotCount);
    end
  endtask

  task automatic test_release_on_frame();
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frames(2, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (vel_if.velocityWriteEnable !== 1'b1 || $signed(vel_if.outVelocityX) !== 11'sd5
                 || $signed(vel_if.outVelocityY) !== -11'sd6) begin
      n_fail++; $display("FAIL coinc_fire got wen=%0d x=%0d y=%0d want 1,5,-6",
                         vel_if.velocityWriteEnable, $signed(vel_if.outVelocityX),
                         $signed(vel_if.outVelocityY));
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle_to_aim();
  endtask

  task automatic test_reset_mid_charge();
    int pulses;
    pulses = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frames(5, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (aimEnable !== 1'b0 || power !== 8'd0 || shotCount !== 8'd0) begin
      n_fail++; $display("FAIL rst_charge got aim=%0d pw=%0d shots=%0d want 0,0,0",
                         aimEnable, power, shotCount);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'(i % 2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (vel_if.velocityWriteEnable !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_nowrite got %0d pulses want 0", pulses); end
  endtask

  task automatic test_random();
    bit chg, cw, ccw;
    int ax, ay;
    chg = 0; cw = 0; ccw = 0;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 29) == 0) chg = ~chg;
      if ($urandom_range(0, 19) == 0) cw = ~cw;
      if ($urandom_range(0, 19) == 0) ccw = ~ccw;
      tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 19) != 0), cw, ccw, chg,
           ($urandom_range(0, 1499) == 0));
      ax = $signed(vel_if.outVelocityX);
      ay = $signed(vel_if.outVelocityY);
      n_cmp++;
      if (aimAngle !== 4'(m_ang) || power !== 8'(m_pw) || aimEnable !== 1'(m_aim())
          || shotCount !== 8'(m_shots) || vel_if.velocityWriteEnable !== 1'(m_wen)
          || ax != m_vx || ay != m_vy) begin
        n_fail++;
        $display("FAIL random@%0d got ang=%0d pw=%0d aim=%0d sh=%0d wen=%0d x=%0d y=%0d want %0d %0d %0d %0d %0d %0d %0d",
                 i, aimAngle, power, aimEnable, shotCount, vel_if.velocityWriteEnable, ax, ay,
                 m_ang, m_pw, m_aim(), m_shots, m_wen, m_vx, m_vy);
      end
    end
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; ballStopped = 1'b0;
    keyRotateCW = 1'b0; keyRotateCCW = 1'b0; keyCharge = 1'b0;
    test_reset();
    test_settle();
    test_rotate();
    test_charge_saturate();
    test_angle2_shot();
    test_cancel();
    test_release_on_frame();
    test_reset_mid_charge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
